// File: rtl/regfile_access_controller_pkg.sv
// Shared GPR constants and front-end FSM state encodings for the register
// file access controller.
package mips_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/regfile_access_controller_if.sv
// Decode, execute and writeback handshakes between the pipeline and the
// register file access controller.
interface regfile_access_controller_if;
  import mips_pkg::*;

  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_rs;
  logic [ADDR_W-1:0] dec_rt;
  logic              dec_use_rt;

  logic              opnd_valid;
  logic              opnd_ready;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (
    output dec_valid, dec_rs, dec_rt, dec_use_rt, opnd_ready,
           wb_valid, wb_addr, wb_data,
    input  dec_ready, opnd_valid, opnd_a, opnd_b, wb_ready
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rt, dec_use_rt, opnd_ready,
           wb_valid, wb_addr, wb_data,
    output dec_ready, opnd_valid, opnd_a, opnd_b, wb_ready
  );

endinterface

// File: rtl/regfile_access_controller_rf_forward_mux.sv
// Operand select for one source: $0 / unused forces zero, otherwise a
// same-cycle writeback beats earlier forwarded data, which beats the RAM.
module rf_forward_mux
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] src_idx,
  input  logic              src_en,
  input  logic              wb_fire,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              fwd_valid,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic              wb_match,
  output logic [DATA_W-1:0] operand
);

  logic live;

  assign live     = src_en && (src_idx != ZERO_REG);
  assign wb_match = live && wb_fire && (wb_addr == src_idx);

  always_comb begin
    operand = '0;
    if (live) begin
      if (wb_match)       operand = wb_data;
      else if (fwd_valid) operand = fwd_data;
      else                operand = rf_data;
    end
  end

endmodule

// File: rtl/regfile_access_controller.sv
// Register file front end: sequences operand fetch across the registered
// read, forwards in-flight writebacks and routes writes to the write port.
module regfile_access_controller
  import mips_pkg::*;
#(
  parameter int RF_ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  regfile_access_controller_if.slave bus,
  output logic                    rf_write_enable,
  output logic                    rf_second_read,
  output logic [RF_ADDR_W-1:0]    rf_read_address_1,
  output logic [RF_ADDR_W-1:0]    rf_read_address_2,
  output logic [RF_ADDR_W-1:0]    rf_write_address,
  output logic [DATA_W-1:0]       rf_write_data,
  input  logic [DATA_W-1:0]       rf_read_data_1,
  input  logic [DATA_W-1:0]       rf_read_data_2
);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] rs_reg;
  logic [ADDR_W-1:0] rt_reg;
  logic              use_rt_reg;
  logic              opnd_valid_reg;
  logic              wb_ready_reg;
  logic [1:0]        fwd_reg;
  logic [DATA_W-1:0] fwd_data_reg [2];
  logic [DATA_W-1:0] opnd_reg     [2];

  logic [ADDR_W-1:0] src_idx [2];
  logic [1:0]        src_en;
  logic [DATA_W-1:0] rf_data [2];
  logic [DATA_W-1:0] operand [2];
  logic [1:0]        wb_match;
  logic              wb_fire;

  assign wb_fire = bus.wb_valid && wb_ready_reg;

  assign bus.dec_ready  = (state_reg == ST_IDLE);
  assign bus.opnd_valid = opnd_valid_reg;
  assign bus.opnd_a     = opnd_reg[0];
  assign bus.opnd_b     = opnd_reg[1];
  assign bus.wb_ready   = wb_ready_reg;

  // Write port is a pure pass-through of the accepted writeback; $0 never strobes.
  assign rf_write_enable  = wb_fire && (bus.wb_addr != ZERO_REG);
  assign rf_write_address = wb_fire ? RF_ADDR_W'(bus.wb_addr) : '0;
  assign rf_write_data    = wb_fire ? bus.wb_data : '0;

  assign rf_read_address_1 = RF_ADDR_W'(rs_reg);
  assign rf_read_address_2 = RF_ADDR_W'(rt_reg);
  assign rf_second_read    = (state_reg == ST_READ) && use_rt_reg;

  assign src_idx[0] = rs_reg;
  assign src_idx[1] = rt_reg;
  assign src_en     = {use_rt_reg, 1'b1};
  assign rf_data[0] = rf_read_data_1;
  assign rf_data[1] = rf_read_data_2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
      rf_forward_mux u_mux (
        .src_idx   (src_idx[gi]),
        .src_en    (src_en[gi]),
        .wb_fire   (wb_fire),
        .wb_addr   (bus.wb_addr),
        .wb_data   (bus.wb_data),
        .fwd_valid (fwd_reg[gi]),
        .fwd_data  (fwd_data_reg[gi]),
        .rf_data   (rf_data[gi]),
        .wb_match  (wb_match[gi]),
        .operand   (operand[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      rs_reg         <= '0;
      rt_reg         <= '0;
      use_rt_reg     <= 1'b0;
      opnd_valid_reg <= 1'b0;
      wb_ready_reg   <= 1'b0;
      fwd_reg        <= '0;
      for (int i = 0; i < 2; i++) begin
        fwd_data_reg[i] <= '0;
        opnd_reg[i]     <= '0;
      end
    end else begin
      wb_ready_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (bus.dec_valid) begin
            rs_reg     <= bus.dec_rs;
            rt_reg     <= bus.dec_rt;
            use_rt_reg <= bus.dec_use_rt;
            state_reg  <= ST_READ;
          end
        end
        ST_READ: begin
          // The RAM samples the old value this cycle, so remember the new one.
          for (int i = 0; i < 2; i++) begin
            if (wb_match[i]) begin
              fwd_reg[i]      <= 1'b1;
              fwd_data_reg[i] <= bus.wb_data;
            end
          end
          state_reg <= ST_LOAD;
        end
        ST_LOAD: begin
          for (int i = 0; i < 2; i++) opnd_reg[i] <= operand[i];
          opnd_valid_reg <= 1'b1;
          state_reg      <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.opnd_ready) begin
            opnd_valid_reg <= 1'b0;
            fwd_reg        <= '0;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
